// File: rtl/microwave_timer_ctrl_if.sv
// ---------------------------------------------------------------------------
// microwave_timer_ctrl_if
//
// Purpose: bundles the keypad/control strobes and the display/status outputs
// of the microwave cook-time controller into a single interface.
//
// Handshake semantics: every strobe (tick_1hz, key_valid, start, clear) is a
// single-cycle valid pulse with an implicit, always-asserted ready. The
// controller samples each strobe on the clock edge where it is high. Depending
// on the current state and the per-cycle priority, the controller either acts
// on the strobe or drops it. There is no back-pressure. door_closed is a
// level, not a strobe.
//
// Signals:
//   tick_1hz     1-cycle 1 Hz pacing pulse           (master -> slave)
//   key_valid    1-cycle strobe, key_value is valid  (master -> slave)
//   key_value    BCD digit, 10-15 are dropped        (master -> slave)
//   start        1-cycle start/resume strobe         (master -> slave)
//   clear        1-cycle stop/clear strobe           (master -> slave)
//   door_closed  level, 1 = door closed              (master -> slave)
//   sec_ones     BCD seconds units                   (slave -> master)
//   sec_tens     BCD seconds tens                    (slave -> master)
//   mins         BCD minutes                         (slave -> master)
//   running      high while counting down            (slave -> master)
//   magnetron_on running and door closed             (slave -> master)
//   done_beep    high in DONE                        (slave -> master)
//   state_o      IDLE=0 RUN=1 PAUSE=2 DONE=3         (slave -> master)
// ---------------------------------------------------------------------------
interface microwave_timer_ctrl_if;
  logic       tick_1hz;
  logic       key_valid;
  logic [3:0] key_value;
  logic       start;
  logic       clear;
  logic       door_closed;
  logic [3:0] sec_ones;
  logic [3:0] sec_tens;
  logic [3:0] mins;
  logic       running;
  logic       magnetron_on;
  logic       done_beep;
  logic [1:0] state_o;

  modport master (
    output tick_1hz, key_valid, key_value, start, clear, door_closed,
    input  sec_ones, sec_tens, mins, running, magnetron_on, done_beep, state_o
  );

  modport slave (
    input  tick_1hz, key_valid, key_value, start, clear, door_closed,
    output sec_ones, sec_tens, mins, running, magnetron_on, done_beep, state_o
  );
endinterface

// File: rtl/microwave_timer_ctrl.sv
// ---------------------------------------------------------------------------
// microwave_timer_ctrl
//
// Purpose: cook-time sequencer for a microwave oven. Its functions are:
//   - it takes keypad digits into a three-digit M:SS shift register,
//   - it counts that time down on 1 Hz enable pulses,
//   - it gates the magnetron with the door interlock,
//   - it sounds a done beep for DONE_HOLD ticks.
//
// Ports:
//   clk   system clock
//   rst   asynchronous, active-high reset
//   bus   microwave_timer_ctrl_if.slave. It carries the tick, keypad,
//         start, clear and door inputs, and the BCD digit, running,
//         magnetron_on, done_beep and state_o outputs.
//
// Parameter:
//   DONE_HOLD  number of tick_1hz pulses spent beeping in DONE before the
//              automatic return to IDLE (must be >= 1).
//
// Build option:
//   QUICK_START_EN  If this macro is defined, start in IDLE at 0:00 with the
//                   door closed loads 0:30 and runs. If it is undefined, such
//                   a start is ignored.
//
// Per-cycle priority of simultaneous inputs, from highest to lowest:
//   clear, door open, start, tick_1hz, key_valid.
// Only the highest-priority input that has a meaning in the current state is
// acted on. Lower-priority inputs in the same cycle are dropped.
// ---------------------------------------------------------------------------
module microwave_timer_ctrl #(
  parameter int unsigned DONE_HOLD = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  microwave_timer_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int unsigned HOLD_W = (DONE_HOLD < 2) ? 1 : $clog2(DONE_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(DONE_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

  state_e            state_q, state_d;
  logic [3:0]        ones_q, ones_d;
  logic [3:0]        tens_q, tens_d;
  logic [3:0]        mins_q, mins_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              running_q, running_d;
  logic              magnetron_q, magnetron_d;
  logic              beep_q, beep_d;

  logic time_zero;
  logic time_one;
  logic key_ok;
  logic door_open;

  assign time_zero = (mins_q == 4'd0) && (tens_q == 4'd0) && (ones_q == 4'd0);
  assign time_one  = (mins_q == 4'd0) && (tens_q == 4'd0) && (ones_q == 4'd1);
  // Out-of-range key codes (10-15) are treated as if no key was pressed.
  assign key_ok    = bus.key_valid && (bus.key_value <= 4'd9);
  assign door_open = !bus.door_closed;

  // -------------------------------------------------------------------------
  // State and datapath registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ones_q      <= 4'd0;
      tens_q      <= 4'd0;
      mins_q      <= 4'd0;
      hold_q      <= '0;
      running_q   <= 1'b0;
      magnetron_q <= 1'b0;
      beep_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ones_q      <= ones_d;
      tens_q      <= tens_d;
      mins_q      <= mins_d;
      hold_q      <= hold_d;
      running_q   <= running_d;
      magnetron_q <= magnetron_d;
      beep_q      <= beep_d;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state, datapath and registered-output logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    ones_d  = ones_q;
    tens_d  = tens_q;
    mins_d  = mins_q;
    hold_d  = hold_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.clear) begin
          ones_d = 4'd0;
          tens_d = 4'd0;
          mins_d = 4'd0;
        end else if (bus.start) begin
          // A start pulse is consumed here even when it cannot take effect.
          // A key in the same cycle is dropped.
          if (bus.door_closed) begin
            if (!time_zero) begin
              state_d = ST_RUN;
            end
`ifdef QUICK_START_EN
            else begin
              mins_d  = 4'd0;
              tens_d  = 4'd3;
              ones_d  = 4'd0;
              state_d = ST_RUN;
            end
`endif
          end
        end else if (key_ok) begin
          // Shift left. The old minutes digit falls off. Digits are not
          // range-checked, so a seconds-tens value of 6-9 is legal.
          mins_d = tens_q;
          tens_d = ones_q;
          ones_d = bus.key_value;
        end
      end

      ST_RUN: begin
        if (bus.clear || door_open) begin
          state_d = ST_PAUSE;
        end else if (bus.tick_1hz) begin
          if (time_one) begin
            ones_d  = 4'd0;
            state_d = ST_DONE;
          end else if (!time_zero) begin
            if (ones_q != 4'd0) begin
              ones_d = ones_q - 4'd1;
            end else begin
              ones_d = 4'd9;
              if (tens_q != 4'd0) begin
                tens_d = tens_q - 4'd1;
              end else begin
                tens_d = 4'd5;
                mins_d = mins_q - 4'd1;
              end
            end
          end
        end
      end

      ST_PAUSE: begin
        if (bus.clear) begin
          state_d = ST_IDLE;
          ones_d  = 4'd0;
          tens_d  = 4'd0;
          mins_d  = 4'd0;
        end else if (bus.start && bus.door_closed) begin
          state_d = ST_RUN;
        end
      end

      ST_DONE: begin
        ones_d = 4'd0;
        tens_d = 4'd0;
        mins_d = 4'd0;
        if (bus.clear || door_open) begin
          state_d = ST_IDLE;
          hold_d  = '0;
        end else if (bus.tick_1hz) begin
          if (hold_q + HOLD_ONE >= HOLD_LAST) begin
            state_d = ST_IDLE;
            hold_d  = '0;
          end else begin
            hold_d = hold_q + HOLD_ONE;
          end
        end else if (key_ok) begin
          // The key only cancels the beep. It is not entered as a digit.
          state_d = ST_IDLE;
          hold_d  = '0;
        end
      end

      default: begin
        state_d = ST_IDLE;
        hold_d  = '0;
      end
    endcase

    // These outputs are registered from the next state, so they line up
    // with the digits and state_o in the same cycle.
    running_d   = (state_d == ST_RUN);
    magnetron_d = running_d && bus.door_closed;
    beep_d      = (state_d == ST_DONE) && (hold_d < HOLD_LAST);
  end

  assign bus.sec_ones     = ones_q;
  assign bus.sec_tens     = tens_q;
  assign bus.mins         = mins_q;
  assign bus.running      = running_q;
  assign bus.magnetron_on = magnetron_q;
  assign bus.done_beep    = beep_q;
  assign bus.state_o      = state_q;

endmodule

// File: tb/tb_microwave_timer_ctrl.sv
// ---------------------------------------------------------------------------
// tb_microwave_timer_ctrl
//
// Directed scenario tasks followed by a randomized run. The randomized run
// is checked against a behavioural model that holds the cook time as
// minutes plus a 0-99 seconds field.
// ---------------------------------------------------------------------------
module tb_microwave_timer_ctrl;

  localparam int DONE_HOLD = 3;
  localparam int S_IDLE = 0, S_RUN = 1, S_PAUSE = 2, S_DONE = 3;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  microwave_timer_ctrl_if bus();

  microwave_timer_ctrl #(.DONE_HOLD(DONE_HOLD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // -------------------------------------------------------------------------
  // Clock / reset
  // -------------------------------------------------------------------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // -------------------------------------------------------------------------
  // Driver tasks. Each task is entered at a falling edge and returns at the
  // next falling edge. The DUT has sampled the input by then.
  // -------------------------------------------------------------------------
  task automatic idle_cyc();
    @(negedge clk);
  endtask

  task automatic press_key(input logic [3:0] v);
    bus.key_value = v;
    bus.key_valid = 1'b1;
    @(negedge clk);
    bus.key_valid = 1'b0;
  endtask

  task automatic press_start();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic press_clear();
    bus.clear = 1'b1;
    @(negedge clk);
    bus.clear = 1'b0;
  endtask

  task automatic pulse_tick();
    bus.tick_1hz = 1'b1;
    @(negedge clk);
    bus.tick_1hz = 1'b0;
  endtask

  function automatic logic [11:0] shown();
    return {bus.mins, bus.sec_tens, bus.sec_ones};
  endfunction

  function automatic logic [4:0] status();
    return {bus.state_o, bus.running, bus.magnetron_on, bus.done_beep};
  endfunction

  // -------------------------------------------------------------------------
  // Directed scenarios
  // -------------------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b1;
    idle_cyc();
    n_cmp++;
    if (status() !== 5'b00_000 || shown() !== 12'h000) begin
      n_err++;
      $display("FAIL reset: status=%b time=%h expected status=00000 time=000", status(), shown());
    end
    rst = 1'b0;
    idle_cyc();
  endtask

  task automatic test_key_entry();
    press_key(4'd1);
    press_key(4'd2);
    press_key(4'd3);
    n_cmp++;
    if (shown() !== 12'h123) begin
      n_err++;
      $display("FAIL key_123: got %h expected 123", shown());
    end
    press_key(4'd12);
    n_cmp++;
    if (shown() !== 12'h123) begin
      n_err++;
      $display("FAIL key_invalid: got %h expected 123", shown());
    end
    press_key(4'd5);
    n_cmp++;
    if (shown() !== 12'h235 || status() !== 5'b00_000) begin
      n_err++;
      $display("FAIL key_shift: time=%h status=%b expected 235 / 00000", shown(), status());
    end
    press_clear();
    n_cmp++;
    if (shown() !== 12'h000) begin
      n_err++;
      $display("FAIL idle_clear: got %h expected 000", shown());
    end
  endtask

  task automatic test_countdown();
    press_key(4'd1);
    press_key(4'd0);
    press_key(4'd0);
    press_start();
    n_cmp++;
    if (status() !== 5'b01_110 || shown() !== 12'h100) begin
      n_err++;
      $display("FAIL run_start: status=%b time=%h expected 01110 / 100", status(), shown());
    end
    pulse_tick();
    n_cmp++;
    if (shown() !== 12'h059) begin
      n_err++;
      $display("FAIL min_borrow: got %h expected 059", shown());
    end
    for (int i = 0; i < 58; i++) pulse_tick();
    n_cmp++;
    if (shown() !== 12'h001 || status() !== 5'b01_110) begin
      n_err++;
      $display("FAIL at_0_01: time=%h status=%b expected 001 / 01110", shown(), status());
    end
    pulse_tick();
    n_cmp++;
    if (shown() !== 12'h000 || status() !== 5'b11_001) begin
      n_err++;
      $display("FAIL reach_done: time=%h status=%b expected 000 / 11001", shown(), status());
    end
    press_clear();
    n_cmp++;
    if (status() !== 5'b00_000) begin
      n_err++;
      $display("FAIL done_clear: status=%b expected 00000", status());
    end
  endtask

  task automatic test_door_pause();
    press_key(4'd1);
    press_key(4'd0);
    press_start();
    bus.door_closed = 1'b0;
    pulse_tick();
    n_cmp++;
    if (shown() !== 12'h010 || status() !== 5'b10_000) begin
      n_err++;
      $display("FAIL door_pause: time=%h status=%b expected 010 / 10000", shown(), status());
    end
    press_start();
    n_cmp++;
    if (status() !== 5'b10_000) begin
      n_err++;
      $display("FAIL start_door_open: status=%b expected 10000", status());
    end
    bus.door_closed = 1'b1;
    idle_cyc();
    press_start();
    pulse_tick();
    n_cmp++;
    if (shown() !== 12'h009 || status() !== 5'b01_110) begin
      n_err++;
      $display("FAIL resume_tick: time=%h status=%b expected 009 / 01110", shown(), status());
    end
    press_clear();
    press_clear();
  endtask

  task automatic test_clear_and_reset();
    press_key(4'd2);
    press_key(4'd0);
    press_start();
    pulse_tick();
    press_clear();
    n_cmp++;
    if (shown() !== 12'h019 || status() !== 5'b10_000) begin
      n_err++;
      $display("FAIL run_clear: time=%h status=%b expected 019 / 10000", shown(), status());
    end
    pulse_tick();
    press_key(4'd7);
    n_cmp++;
    if (shown() !== 12'h019) begin
      n_err++;
      $display("FAIL pause_ignores: got %h expected 019", shown());
    end
    press_clear();
    n_cmp++;
    if (shown() !== 12'h000 || status() !== 5'b00_000) begin
      n_err++;
      $display("FAIL pause_clear: time=%h status=%b expected 000 / 00000", shown(), status());
    end
    press_key(4'd5);
    press_start();
    pulse_tick();
    // Assert reset between clock edges. The outputs must drop before the
    // next rising edge.
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if (shown() !== 12'h000 || status() !== 5'b00_000) begin
      n_err++;
      $display("FAIL async_reset: time=%h status=%b expected 000 / 00000", shown(), status());
    end
    @(negedge clk);
    rst = 1'b0;
    idle_cyc();
  endtask

  task automatic test_done_hold();
    press_key(4'd1);
    press_start();
    pulse_tick();
    for (int i = 1; i < DONE_HOLD; i++) begin
      pulse_tick();
      n_cmp++;
      if (status() !== 5'b11_001) begin
        n_err++;
        $display("FAIL done_hold_%0d: status=%b expected 11001", i, status());
      end
    end
    pulse_tick();
    n_cmp++;
    if (status() !== 5'b00_000 || shown() !== 12'h000) begin
      n_err++;
      $display("FAIL done_expire: status=%b time=%h expected 00000 / 000", status(), shown());
    end
  endtask

  task automatic test_done_key();
    press_key(4'd2);
    press_start();
    pulse_tick();
    pulse_tick();
    n_cmp++;
    if (status() !== 5'b11_001) begin
      n_err++;
      $display("FAIL done_enter: status=%b expected 11001", status());
    end
    press_key(4'd7);
    n_cmp++;
    if (status() !== 5'b00_000 || shown() !== 12'h000) begin
      n_err++;
      $display("FAIL done_key: status=%b time=%h expected 00000 / 000", status(), shown());
    end
  endtask

  task automatic test_quick_start();
    press_start();
`ifdef QUICK_START_EN
    n_cmp++;
    if (shown() !== 12'h030 || status() !== 5'b01_110) begin
      n_err++;
      $display("FAIL quick_start: time=%h status=%b expected 030 / 01110", shown(), status());
    end
    press_clear();
    press_clear();
`else
    n_cmp++;
    if (shown() !== 12'h000 || status() !== 5'b00_000) begin
      n_err++;
      $display("FAIL zero_start: time=%h status=%b expected 000 / 00000", shown(), status());
    end
`endif
  endtask

  // -------------------------------------------------------------------------
  // Reference model: the cook time is held as minutes plus a seconds field
  // of 0-99. This allows values such as 0:75 to be entered.
  // -------------------------------------------------------------------------
  int m_state, m_min, m_sec, m_hold;
  logic m_mag;

  task automatic model_reset();
    m_state = S_IDLE; m_min = 0; m_sec = 0; m_hold = 0; m_mag = 1'b0;
  endtask

  task automatic model_step(input bit tk, input bit kv, input int kval,
                            input bit st, input bit cl, input bit dc);
    bit key_ok;
    key_ok = kv && (kval <= 9);
    case (m_state)
      S_IDLE: begin
        if (cl) begin
          m_min = 0; m_sec = 0;
        end else if (st) begin
          if (dc && (m_min != 0 || m_sec != 0)) m_state = S_RUN;
`ifdef QUICK_START_EN
          else if (dc) begin m_min = 0; m_sec = 30; m_state = S_RUN; end
`endif
        end else if (key_ok) begin
          // The entered digits form the new seconds field. The seconds tens
          // digit moves up to become the minutes digit.
          m_min = m_sec / 10;
          m_sec = (m_sec % 10) * 10 + kval;
        end
      end
      S_RUN: begin
        if (cl || !dc) m_state = S_PAUSE;
        else if (tk) begin
          if (m_min == 0 && m_sec == 1) begin m_sec = 0; m_state = S_DONE; end
          else if (m_sec > 0) m_sec = m_sec - 1;
          else if (m_min > 0) begin m_min = m_min - 1; m_sec = 59; end
        end
      end
      S_PAUSE: begin
        if (cl) begin m_state = S_IDLE; m_min = 0; m_sec = 0; end
        else if (st && dc) m_state = S_RUN;
      end
      default: begin
        if (cl || !dc) begin m_state = S_IDLE; m_hold = 0; end
        else if (tk) begin
          m_hold = m_hold + 1;
          if (m_hold >= DONE_HOLD) begin m_state = S_IDLE; m_hold = 0; end
        end else if (key_ok) begin m_state = S_IDLE; m_hold = 0; end
      end
    endcase
    m_mag = (m_state == S_RUN) && dc;
  endtask

  task automatic test_random();
    bit tk, kv, st, cl, dc;
    int kval;
    logic [11:0] exp_t;
    logic [4:0]  exp_s;
    rst = 1'b1;
    idle_cyc();
    rst = 1'b0;
    model_reset();
    dc = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      exp_t = {4'(m_min), 4'(m_sec / 10), 4'(m_sec % 10)};
      exp_s = {2'(m_state), (m_state == S_RUN), m_mag, (m_state == S_DONE)};
      n_cmp++;
      if (shown() !== exp_t || status() !== exp_s) begin
        n_err++;
        $display("FAIL random_c%0d: time=%h status=%b expected %h / %b", c, shown(), status(), exp_t, exp_s);
      end
      tk   = ($urandom_range(0, 2) == 0);
      kv   = ($urandom_range(0, 3) == 0);
      kval = ($urandom_range(0, 9) < 8) ? int'($urandom_range(0, 1)) : int'($urandom_range(0, 15));
      st   = ($urandom_range(0, 7) == 0);
      cl   = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 19) == 0) dc = !dc;
      bus.tick_1hz    = tk;
      bus.key_valid   = kv;
      bus.key_value   = 4'(kval);
      bus.start       = st;
      bus.clear       = cl;
      bus.door_closed = dc;
      @(posedge clk);
      model_step(tk, kv, kval, st, cl, dc);
      @(negedge clk);
    end
    bus.tick_1hz = 1'b0;
    bus.key_valid = 1'b0;
    bus.start = 1'b0;
    bus.clear = 1'b0;
    bus.door_closed = 1'b1;
  endtask

  // -------------------------------------------------------------------------
  // Sequence and report
  // -------------------------------------------------------------------------
  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    bus.tick_1hz    = 1'b0;
    bus.key_valid   = 1'b0;
    bus.key_value   = 4'd0;
    bus.start       = 1'b0;
    bus.clear       = 1'b0;
    bus.door_closed = 1'b1;
    test_reset();
    test_key_entry();
    test_countdown();
    test_door_pause();
    test_clear_and_reset();
    test_done_hold();
    test_done_key();
    test_quick_start();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
